// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALUOp/forwarding encodings and control-bundle layout
package mips_pkg;

    // Opcodes understood by the upstream decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Bit positions in the registered 1-bit control bundle (Jump is consumed in ID only)
    localparam int CB_REGDST   = 0;
    localparam int CB_BRANCH   = 1;
    localparam int CB_MEMREAD  = 2;
    localparam int CB_MEMTOREG = 3;
    localparam int CB_MEMWRITE = 4;
    localparam int CB_ALUSRC   = 5;
    localparam int CB_REGWRITE = 6;
    localparam int CB_W        = 7;

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall, branch/jump redirect and operand forwarding selects
module hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_id_valid,
    input  logic             i_id_jump,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_v,
    input  logic             i_ex_memread,
    input  logic             i_ex_branch,
    input  logic             i_ex_zero,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_mem_v,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_mem_wreg,
    input  logic             i_wb_v,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_wreg,
    output logic             o_stall,
    output logic             o_flush_if_id,
    output logic             o_branch_taken,
    output logic             o_jump_taken,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b
);

    logic w_branch_taken;
    logic w_load_use;
    logic w_stall;
    logic w_jump_taken;
    logic w_mem_src;
    logic w_wb_src;

    // A taken branch outranks a load-use stall: the stalled instruction is squashed anyway
    assign w_branch_taken = i_ex_v & i_ex_branch & i_ex_zero;
    assign w_load_use     = i_id_valid & i_ex_v & i_ex_memread &
                            ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
    assign w_stall        = w_load_use & ~w_branch_taken;
    assign w_jump_taken   = i_id_valid & i_id_jump & ~w_stall & ~w_branch_taken;

    // Register 0 is hardwired, so a write to it never becomes a forwarding source
    assign w_mem_src = i_mem_v & i_mem_regwrite & (i_mem_wreg != '0);
    assign w_wb_src  = i_wb_v & i_wb_regwrite & (i_wb_wreg != '0);

    assign o_branch_taken = w_branch_taken;
    assign o_stall        = w_stall;
    assign o_jump_taken   = w_jump_taken;
    assign o_flush_if_id  = w_branch_taken | w_jump_taken;

    // Pick the youngest producer for each EX operand; MEM is newer than WB
    always_comb begin
        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        if (w_mem_src && (i_mem_wreg == i_ex_rs)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_wb_src && (i_wb_wreg == i_ex_rs)) begin
            o_fwd_a = FWD_WB;
        end
        if (w_mem_src && (i_mem_wreg == i_ex_rt)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_wb_src && (i_wb_wreg == i_ex_rt)) begin
            o_fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX/MEM/WB control-bundle pipeline registers with hazard control
module ctrl_pipe
    import mips_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               id_RegDst,
    input  logic               id_Branch,
    input  logic               id_MemRead,
    input  logic               id_MemToReg,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic               id_RegWrite,
    input  logic               id_Jump,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               ex_zero,
    output logic               ex_RegDst,
    output logic               ex_ALUSrc,
    output logic               ex_Branch,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic               wb_MemToReg,
    output logic               wb_RegWrite,
    output logic [REG_W-1:0]   ex_wreg,
    output logic [REG_W-1:0]   mem_wreg,
    output logic [REG_W-1:0]   wb_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               stall,
    output logic               flush_if_id,
    output logic               branch_taken,
    output logic               jump_taken
);

    logic [CB_W-1:0]    w_id_ctrl;
    logic               w_capture;
    logic               w_stall;
    logic               w_branch_taken;
    logic [REG_W-1:0]   w_ex_wreg;

    logic               r_ex_v;
    logic [CB_W-1:0]    r_ex_ctrl;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [REG_W-1:0]   r_ex_rs;
    logic [REG_W-1:0]   r_ex_rt;
    logic [REG_W-1:0]   r_ex_rd;

    logic               r_mem_v;
    logic               r_mem_memread;
    logic               r_mem_memwrite;
    logic               r_mem_memtoreg;
    logic               r_mem_regwrite;
    logic [REG_W-1:0]   r_mem_wreg;

    logic               r_wb_v;
    logic               r_wb_memtoreg;
    logic               r_wb_regwrite;
    logic [REG_W-1:0]   r_wb_wreg;

    // A stall or taken branch turns the ID slot into a bubble
    assign w_capture = id_valid & ~(w_stall | w_branch_taken);
    assign w_ex_wreg = r_ex_ctrl[CB_REGDST] ? r_ex_rd : r_ex_rt;

    // Pack the ID bundle; only the bits that cause side effects are qualified
    always_comb begin
        w_id_ctrl              = '0;
        w_id_ctrl[CB_REGDST]   = id_RegDst;
        w_id_ctrl[CB_MEMTOREG] = id_MemToReg;
        w_id_ctrl[CB_ALUSRC]   = id_ALUSrc;
        w_id_ctrl[CB_BRANCH]   = w_capture & id_Branch;
        w_id_ctrl[CB_MEMREAD]  = w_capture & id_MemRead;
        w_id_ctrl[CB_MEMWRITE] = w_capture & id_MemWrite;
        w_id_ctrl[CB_REGWRITE] = w_capture & id_RegWrite;
    end

    // Stage registers: EX from ID, MEM from EX, WB from MEM, no downstream backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v         <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_aluop     <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_rd        <= '0;
            r_mem_v        <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_wreg     <= '0;
            r_wb_v         <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_wreg      <= '0;
        end else begin
            r_ex_v         <= w_capture;
            r_ex_ctrl      <= w_id_ctrl;
            r_ex_aluop     <= id_ALUOp;
            r_ex_rs        <= id_rs;
            r_ex_rt        <= id_rt;
            r_ex_rd        <= id_rd;
            r_mem_v        <= r_ex_v;
            r_mem_memread  <= r_ex_ctrl[CB_MEMREAD];
            r_mem_memwrite <= r_ex_ctrl[CB_MEMWRITE];
            r_mem_memtoreg <= r_ex_ctrl[CB_MEMTOREG];
            r_mem_regwrite <= r_ex_ctrl[CB_REGWRITE];
            r_mem_wreg     <= w_ex_wreg;
            r_wb_v         <= r_mem_v;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_wreg      <= r_mem_wreg;
        end
    end

    hazard_fwd_unit #(
        .REG_W (REG_W)
    ) u_hazard_fwd (
        .i_id_valid     (id_valid),
        .i_id_jump      (id_Jump),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_ex_v         (r_ex_v),
        .i_ex_memread   (r_ex_ctrl[CB_MEMREAD]),
        .i_ex_branch    (r_ex_ctrl[CB_BRANCH]),
        .i_ex_zero      (ex_zero),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .i_mem_v        (r_mem_v),
        .i_mem_regwrite (r_mem_regwrite),
        .i_mem_wreg     (r_mem_wreg),
        .i_wb_v         (r_wb_v),
        .i_wb_regwrite  (r_wb_regwrite),
        .i_wb_wreg      (r_wb_wreg),
        .o_stall        (w_stall),
        .o_flush_if_id  (flush_if_id),
        .o_branch_taken (w_branch_taken),
        .o_jump_taken   (jump_taken),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );

    assign stall        = w_stall;
    assign branch_taken = w_branch_taken;

    assign ex_RegDst    = r_ex_ctrl[CB_REGDST];
    assign ex_ALUSrc    = r_ex_ctrl[CB_ALUSRC];
    assign ex_Branch    = r_ex_ctrl[CB_BRANCH];
    assign ex_ALUOp     = r_ex_aluop;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_wreg      = w_ex_wreg;
    assign mem_MemRead  = r_mem_v & r_mem_memread;
    assign mem_MemWrite = r_mem_v & r_mem_memwrite;
    assign mem_wreg     = r_mem_wreg;
    assign wb_MemToReg  = r_wb_memtoreg;
    assign wb_RegWrite  = r_wb_v & r_wb_regwrite;
    assign wb_wreg      = r_wb_wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed vector bench for ctrl_pipe
module tb_ctrl_pipe;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_RegDst, id_Branch, id_MemRead, id_MemToReg;
    logic       id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump;
    logic [1:0] id_ALUOp;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       ex_RegDst, ex_ALUSrc, ex_Branch;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rs, ex_rt;
    logic       mem_MemRead, mem_MemWrite, wb_MemToReg, wb_RegWrite;
    logic [4:0] ex_wreg, mem_wreg, wb_wreg;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, flush_if_id, branch_taken, jump_taken;
    logic [41:0] all_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum { K_NOP, K_RT, K_LW, K_SW, K_BEQ, K_J, K_BLD } kind_e;

    typedef struct {
        kind_e      kind;
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       zero;
        logic       st, fl, br, jm;
        logic [1:0] fa, fb;
        logic       mrd, mwr, wrw;
        logic [4:0] exw, memw, wbw;
    } vec_t;

    vec_t vecs[21];

    ctrl_pipe #(.REG_W(5), .ALUOP_W(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemToReg(id_MemToReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_RegWrite(id_RegWrite), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
        .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush_if_id(flush_if_id),
        .branch_taken(branch_taken), .jump_taken(jump_taken)
    );

    assign all_out = {ex_RegDst, ex_ALUSrc, ex_Branch, ex_ALUOp, ex_rs, ex_rt,
                      mem_MemRead, mem_MemWrite, wb_MemToReg, wb_RegWrite,
                      ex_wreg, mem_wreg, wb_wreg, fwd_a, fwd_b,
                      stall, flush_if_id, branch_taken, jump_taken};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Minimal decoder model: control bits for each instruction class
    task automatic drive(input kind_e k, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic z);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
        {id_RegDst, id_Branch, id_MemRead, id_MemToReg,
         id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump} = 8'h00;
        id_ALUOp = 2'b00;
        case (k)
            K_RT:  begin id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b10; end
            K_LW:  begin id_ALUSrc = 1'b1; id_MemRead = 1'b1; id_MemToReg = 1'b1; id_RegWrite = 1'b1; end
            K_SW:  begin id_ALUSrc = 1'b1; id_MemWrite = 1'b1; end
            K_BEQ: begin id_Branch = 1'b1; id_ALUOp = 2'b01; end
            K_J:   begin id_Jump = 1'b1; end
            K_BLD: begin id_Branch = 1'b1; id_MemRead = 1'b1; id_ALUOp = 2'b01; end
            default: ;
        endcase
    endtask

    function automatic vec_t mk(kind_e k, logic v, int rs, int rt, int rd, logic z,
                                logic st, logic fl, logic br, logic jm,
                                logic [1:0] fa, logic [1:0] fb,
                                logic mrd, logic mwr, logic wrw,
                                int exw, int memw, int wbw);
        vec_t t;
        t.kind = k; t.valid = v; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd); t.zero = z;
        t.st = st; t.fl = fl; t.br = br; t.jm = jm; t.fa = fa; t.fb = fb;
        t.mrd = mrd; t.mwr = mwr; t.wrw = wrw;
        t.exw = 5'(exw); t.memw = 5'(memw); t.wbw = 5'(wbw);
        return t;
    endfunction

    initial begin
        // lw $8 then add $9,$8,$10: one-cycle stall, bubble, WB forward
        vecs[0]  = mk(K_LW,  1, 1, 8, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
        vecs[1]  = mk(K_RT,  1, 8,10, 9, 0,  1,0,0,0, 2'b00,2'b00, 0,0,0, 8,0,0);
        vecs[2]  = mk(K_RT,  1, 8,10, 9, 0,  0,0,0,0, 2'b10,2'b00, 1,0,0, 9,8,0);
        // add $3,$1,$2 then sub $4,$3,$3: MEM forward on both operands
        vecs[3]  = mk(K_RT,  1, 1, 2, 3, 0,  0,0,0,0, 2'b01,2'b00, 0,0,1, 9,9,8);
        vecs[4]  = mk(K_RT,  1, 3, 3, 4, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 3,9,9);
        vecs[5]  = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b10,2'b10, 0,0,1, 4,3,9);
        vecs[6]  = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,1, 0,4,3);
        // beq taken squashes a jump in ID; the following jump redirects on its own
        vecs[7]  = mk(K_BEQ, 1, 5, 6, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,1, 0,0,4);
        vecs[8]  = mk(K_J,   1, 0, 0, 0, 1,  0,1,1,0, 2'b00,2'b00, 0,0,0, 6,0,0);
        vecs[9]  = mk(K_J,   1, 0, 0, 0, 0,  0,1,0,1, 2'b00,2'b00, 0,0,0, 0,6,0);
        vecs[10] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,6);
        vecs[11] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
        vecs[12] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
        // branch with MemRead in EX and a dependent instruction in ID: branch wins
        vecs[13] = mk(K_BLD, 1, 2, 7, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
        vecs[14] = mk(K_RT,  1, 7, 1, 5, 1,  0,1,1,0, 2'b00,2'b00, 0,0,0, 7,0,0);
        vecs[15] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 1,0,0, 5,7,0);
        // write to $0 is never forwarded even though its RegWrite reaches WB
        vecs[16] = mk(K_RT,  1, 1, 2, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,5,7);
        vecs[17] = mk(K_RT,  1, 0, 0, 6, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,5);
        vecs[18] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,0, 6,0,0);
        vecs[19] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,1, 0,6,0);
        vecs[20] = mk(K_NOP, 0, 0, 0, 0, 0,  0,0,0,0, 2'b00,2'b00, 0,0,1, 0,0,6);

        rst = 1'b0;
        drive(K_NOP, 0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 rst = 1'b1;
        #1 check("reset_all_outputs", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        check("reset_held_outputs", 64'(all_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].kind, vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].zero);
            #1;
            check($sformatf("v%0d_stall", i),        64'(stall),        64'(vecs[i].st));
            check($sformatf("v%0d_flush", i),        64'(flush_if_id),  64'(vecs[i].fl));
            check($sformatf("v%0d_branch", i),       64'(branch_taken), 64'(vecs[i].br));
            check($sformatf("v%0d_jump", i),         64'(jump_taken),   64'(vecs[i].jm));
            check($sformatf("v%0d_fwd_a", i),        64'(fwd_a),        64'(vecs[i].fa));
            check($sformatf("v%0d_fwd_b", i),        64'(fwd_b),        64'(vecs[i].fb));
            check($sformatf("v%0d_mem_rd", i),       64'(mem_MemRead),  64'(vecs[i].mrd));
            check($sformatf("v%0d_mem_wr", i),       64'(mem_MemWrite), 64'(vecs[i].mwr));
            check($sformatf("v%0d_wb_regwrite", i),  64'(wb_RegWrite),  64'(vecs[i].wrw));
            check($sformatf("v%0d_ex_wreg", i),      64'(ex_wreg),      64'(vecs[i].exw));
            check($sformatf("v%0d_mem_wreg", i),     64'(mem_wreg),     64'(vecs[i].memw));
            check($sformatf("v%0d_wb_wreg", i),      64'(wb_wreg),      64'(vecs[i].wbw));
            @(posedge clk); #1;
        end

        // sw $9 in MEM when reset asserts mid-cycle
        drive(K_SW, 1, 5'd2, 5'd9, 5'd0, 1'b0);
        @(posedge clk); #1;
        check("sw_ex_alusrc", 64'(ex_ALUSrc), 64'd1);
        drive(K_NOP, 0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        check("sw_mem_write", 64'(mem_MemWrite), 64'd1);
        check("sw_mem_wreg", 64'(mem_wreg), 64'd9);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_memwrite", 64'(mem_MemWrite), 64'd0);
        check("rst_mid_all", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        check("rst_hold_all", 64'(all_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_release_all", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        check("post_rst_idle_all", 64'(all_out), 64'd0);
        drive(K_RT, 1, 5'd1, 5'd2, 5'd3, 1'b0);
        #1 check("post_rst_id_only", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        check("post_rst_ex_wreg", 64'(ex_wreg), 64'd3);
        check("post_rst_ex_rs", 64'(ex_rs), 64'd1);
        check("post_rst_ex_aluop", 64'(ex_ALUOp), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the ID stage through the EX, MEM and WB pipeline registers, so stage logic reads one registered bundle per stage. It also detects load-use hazards and taken branches/jumps, and produces the stall and flush signals for the fetch/decode front end. It sits directly downstream of the opcode decoder and upstream of the datapath stage muxes, ALU control, data memory and register-file write port.

## Interface
- REG_W, 5, register-specifier width
- ALUOP_W, 2, ALUOp width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_RegDst, id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump  in  1 each  decoder outputs for the ID instruction
- id_ALUOp  in  ALUOP_W  decoder ALUOp
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields
- ex_zero  in  1  ALU zero flag for the EX instruction
- ex_RegDst, ex_ALUSrc, ex_Branch  out  1  EX-stage controls
- ex_ALUOp  out  ALUOP_W  EX-stage ALUOp
- ex_rs, ex_rt  out  REG_W  EX operand specifiers
- mem_MemRead, mem_MemWrite  out  1  data-memory strobes, qualified by valid
- wb_MemToReg, wb_RegWrite  out  1  WB controls; wb_RegWrite is qualified by valid
- ex_wreg, mem_wreg, wb_wreg  out  REG_W  destination register per stage
- fwd_a, fwd_b  out  2  operand forwarding selects: 00 = regfile, 10 = MEM, 01 = WB
- stall  out  1  hold PC and the IF/ID register this cycle
- flush_if_id  out  1  squash the IF/ID register at the next edge
- branch_taken, jump_taken  out  1  PC source selects

## Operation
- Qualified bits are RegWrite, MemRead, MemWrite, Branch and Jump.
  - A qualified bit is captured as (id_valid & bit & ~bubble), where bubble = stall | branch_taken.
  - All other bundle bits are captured as-is; their don't-care values are never acted on.
- Each stage register has its own valid bit: ex_v, mem_v, wb_v.
  - EX captures the ID bundle; ex_v is loaded with id_valid & ~bubble.
  - MEM captures EX and WB captures MEM unconditionally every cycle.
  - There is no backpressure downstream of ID.
- ex_wreg = ex_RegDst ? ex_rd : ex_rt, a combinational mux from the EX register. mem_wreg and wb_wreg are pipelined copies.
- Load-use hazard: stall = id_valid & ex_v & ex_MemRead & (ex_rt == id_rs | ex_rt == id_rt) & ~branch_taken.
- branch_taken = ex_v & ex_Branch & ex_zero. It kills the ID instruction (bubble into EX) and asserts flush_if_id.
- jump_taken = id_valid & id_Jump & ~stall & ~branch_taken. It asserts flush_if_id only; the jump itself proceeds as a no-op bundle.
- Forwarding:
  - Select MEM when mem_v & mem_RegWrite & mem_wreg != 0 and mem_wreg matches ex_rs (for fwd_a) or ex_rt (for fwd_b).
  - Otherwise select WB under the same condition on the WB stage.
  - MEM has priority over WB. Register 0 is never forwarded.
- Simultaneous events:
  - Branch taken and stall in the same cycle: the branch wins and stall = 0.
  - Branch taken and jump in ID in the same cycle: the jump is squashed.

## Timing
- Reset (asynchronous, active-high): all valid bits = 0; every registered bundle bit and specifier = 0. Consequently every output = 0, and fwd_a = fwd_b = 00.
- Latency: a bundle presented in cycle n appears on ex_* in n+1, mem_* in n+2 and wb_* in n+3.
- stall, flush_if_id, branch_taken, jump_taken and fwd_* are combinational in the same cycle.
- A load-use stall lasts exactly one cycle. The bubble clears ex_MemRead, so stall deasserts on the next cycle.
- Reset mid-operation: in-flight bundles are discarded and no MemWrite or RegWrite fires after the reset asserts.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams
  - ALUOp encodings (00 add, 01 sub, 10 funct, 11 slt)
  - forwarding-select encodings
  - control-bundle bit positions
- One sub-module, hazard_fwd_unit: combinational stall, branch/jump and forwarding logic. ctrl_pipe holds only the stage registers.

## Test plan
- lw $8 in ID, then add $9,$8,$10 next cycle: stall = 1 for one cycle; EX shows a bubble (all qualified bits 0); add reaches EX one cycle later with fwd_a = 01.
- add $3,$1,$2 followed by sub $4,$3,$3: fwd_a = fwd_b = 10 while sub is in EX.
- beq in EX with ex_zero = 1 and a load-use hazard pending in ID: branch_taken = 1, flush_if_id = 1, stall = 0, and the next EX is a bubble.
- j in ID with id_valid = 1: jump_taken = 1 and flush_if_id = 1 for one cycle; no RegWrite or MemWrite for it appears at MEM or WB.
- Instruction writing $0: wb_RegWrite may assert, but fwd_a and fwd_b remain 00.
- sw in MEM when rst asserts mid-cycle: mem_MemWrite drops to 0 immediately and all outputs stay 0 until the first valid bundle after reset release.
